memory_nop_machine: RTL and testbench



---
 rtl/memory_nop_machine_if.sv | 30 +++
 rtl/memory_nop_machine.sv | 145 ++++++++++++++
 tb/tb_memory_nop_machine.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/memory_nop_machine_if.sv
// memory_nop_machine_if
// Host access port of the NOP machine memory subsystem.
//   host_valid  : host request, held high until host_done
//   host_rd     : 1 = read, 0 = write
//   host_addr   : target address
//   host_wdata  : write data
//   host_rdata  : read data, valid while host_done is high
//   host_done   : one-cycle completion pulse
// The master modport is the host side, the slave modport is the memory subsystem.
interface memory_nop_machine_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              host_valid;
  logic              host_rd;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic [DATA_W-1:0] host_rdata;
  logic              host_done;

  modport master (
    output host_valid, host_rd, host_addr, host_wdata,
    input  host_rdata, host_done
  );

  modport slave (
    input  host_valid, host_rd, host_addr, host_wdata,
    output host_rdata, host_done
  );
endinterface

// File: rtl/memory_nop_machine.sv
// memory_nop_machine
// 2^ADDR_W x DATA_W memory on a multiplexed address/data bus, sequenced by a
// fetch-only processor that treats every byte as a no-op. A host can borrow
// bus slots (ADDR cycle + DATA cycle) to read or write memory; host slots have
// priority over machine fetches.
// Ports:
//   CLK        : clock, rising edge
//   RST        : asynchronous active-low reset
//   host       : host access port (slave side), see memory_nop_machine_if
//   is_running : high once the machine has left reset
//   pc         : address of the next machine fetch
//   ir         : last byte fetched by the machine
//   uni_bus    : observation copy of the internal bus (8'h00 when undriven)
// ADDR_W is expected not to exceed DATA_W, since addresses travel on the bus.
module memory_nop_machine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  memory_nop_machine_if.slave   host,
  output logic                  is_running,
  output logic [ADDR_W-1:0]     pc,
  output logic [DATA_W-1:0]     ir,
  output logic [DATA_W-1:0]     uni_bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // Storage is never reset; contents survive RST.
  logic [DATA_W-1:0] mem [DEPTH];

  state_t            r_state;
  logic              r_host_slot;  // current slot belongs to the host
  logic              r_rd;         // direction registered in the ADDR cycle
  logic [ADDR_W-1:0] r_addr;       // address registered in the ADDR cycle
  logic [DATA_W-1:0] r_wdata;      // host write data captured in the ADDR cycle
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic              r_running;
  logic              r_host_done;
  logic [DATA_W-1:0] r_host_rdata;

  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_bus;

  // Slot owner's address for the ADDR cycle: host wins whenever it requests.
  always_comb begin
    w_addr = r_pc;
    if (host.host_valid) begin
      w_addr = host.host_addr;
    end else begin
      w_addr = r_pc;
    end
  end

  // Single bus driver per cycle; idle bus reads as zero.
  always_comb begin
    w_bus = {DATA_W{1'b0}};
    case (r_state)
      ST_ADDR: w_bus = DATA_W'(w_addr);
      ST_DATA: begin
        if (r_rd) begin
          w_bus = mem[r_addr];
        end else begin
          w_bus = r_wdata;
        end
      end
      default: w_bus = {DATA_W{1'b0}};
    endcase
  end

  // Slot sequencer: owner arbitration, fetch bookkeeping and host completion.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= ST_IDLE;
      r_host_slot  <= 1'b0;
      r_rd         <= 1'b1;
      r_addr       <= {ADDR_W{1'b0}};
      r_wdata      <= {DATA_W{1'b0}};
      r_pc         <= {ADDR_W{1'b0}};
      r_ir         <= {DATA_W{1'b0}};
      r_running    <= 1'b0;
      r_host_done  <= 1'b0;
      r_host_rdata <= {DATA_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state     <= ST_ADDR;
          r_running   <= 1'b1;
          r_host_done <= 1'b0;
        end
        ST_ADDR: begin
          // Host inputs are only looked at here; machine slots are always reads.
          r_host_slot <= host.host_valid;
          r_rd        <= host.host_valid ? host.host_rd : 1'b1;
          r_wdata     <= host.host_valid ? host.host_wdata : {DATA_W{1'b0}};
          r_addr      <= w_addr;
          r_host_done <= 1'b0;
          r_state     <= ST_DATA;
        end
        ST_DATA: begin
          if (r_host_slot) begin
            if (r_rd) begin
              r_host_rdata <= w_bus;
            end
            r_host_done <= 1'b1;
          end else begin
            r_ir        <= w_bus;
            r_pc        <= r_pc + PC_STEP;
            r_host_done <= 1'b0;
          end
          r_state <= ST_ADDR;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_host_done <= 1'b0;
        end
      endcase
    end
  end

  // Write commit at the end of a host write DATA cycle. Reset forces the
  // sequencer out of DATA asynchronously, so an interrupted write never lands.
  always_ff @(posedge CLK) begin
    if ((r_state == ST_DATA) && r_host_slot && !r_rd) begin
      mem[r_addr] <= w_bus;
    end
  end

  assign is_running      = r_running;
  assign pc              = r_pc;
  assign ir              = r_ir;
  assign uni_bus         = w_bus;
  assign host.host_done  = r_host_done;
  assign host.host_rdata = r_host_rdata;

endmodule

// File: tb/tb_memory_nop_machine.sv
// Scoreboard bench for memory_nop_machine: host transfers push their expected
// outcome into a queue, a negedge monitor pops on every host_done and checks
// every machine fetch against a reference memory image.
module tb_memory_nop_machine;

  logic       CLK;
  logic       RST;
  logic       is_running;
  logic [7:0] pc;
  logic [7:0] ir;
  logic [7:0] uni_bus;

  memory_nop_machine_if #(.ADDR_W(8), .DATA_W(8)) host_if ();

  memory_nop_machine #(.ADDR_W(8), .DATA_W(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .host       (host_if),
    .is_running (is_running),
    .pc         (pc),
    .ir         (ir),
    .uni_bus    (uni_bus)
  );

  typedef struct packed {
    logic       rd;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } hent_t;

  hent_t      host_q [$];
  logic [7:0] model_mem [256];
  int         n_checks;
  int         n_errors;
  int         n_fetch;
  int         n_done;
  bit         wrap_seen;
  logic [7:0] prev_pc;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check8({tag, "_is_running"}, {7'b0, is_running}, 8'h00);
    check8({tag, "_pc"}, pc, 8'h00);
    check8({tag, "_ir"}, ir, 8'h00);
    check8({tag, "_host_done"}, {7'b0, host_if.host_done}, 8'h00);
    check8({tag, "_host_rdata"}, host_if.host_rdata, 8'h00);
    check8({tag, "_uni_bus"}, uni_bus, 8'h00);
  endtask

  // Issue one host transfer and wait (bounded) for its done pulse.
  // keep=1 leaves host_valid high so the next call chains back-to-back.
  task automatic host_xfer(input logic rd, input logic [7:0] addr, input logic [7:0] wdata,
                           input logic [7:0] exp, input bit keep, output int cyc);
    hent_t e;
    bit    got;
    host_if.host_rd    = rd;
    host_if.host_addr  = addr;
    host_if.host_wdata = wdata;
    host_if.host_valid = 1'b1;
    e.rd = rd; e.addr = addr; e.wdata = wdata; e.rdata = exp;
    host_q.push_back(e);
    got = 1'b0;
    cyc = 0;
    for (int c = 0; c < 12 && !got; c++) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (host_if.host_done) got = 1'b1;
    end
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL host_done_timeout addr %h: got no pulse expected one within 12 cycles", addr);
    end else begin
      n_done++;
    end
    if (!keep) host_if.host_valid = 1'b0;
  endtask

  // Monitor: pops the scoreboard on host_done, checks each machine fetch.
  initial begin
    hent_t e;
    prev_pc = 8'h00;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        prev_pc = 8'h00;
      end else begin
        if (host_if.host_done) begin
          if (host_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL host_done_unexpected: got pulse expected none");
          end else begin
            e = host_q.pop_front();
            if (e.rd) check8("host_rdata", host_if.host_rdata, e.rdata);
            else model_mem[e.addr] = e.wdata;
          end
        end
        if (pc != prev_pc) begin
          check8("fetch_pc", pc, prev_pc + 8'h01);
          check8("fetch_ir", ir, model_mem[prev_pc]);
          if (prev_pc == 8'hFF) wrap_seen = 1'b1;
          prev_pc = pc;
          n_fetch++;
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    logic [7:0] v;
    logic [7:0] p0;
    logic [7:0] p_frz;
    int         cyc;
    bit         moved;
    n_checks = 0; n_errors = 0; n_fetch = 0; n_done = 0; wrap_seen = 1'b0;
    RST = 1'b0;
    host_if.host_valid = 1'b0;
    host_if.host_rd    = 1'b0;
    host_if.host_addr  = 8'h00;
    host_if.host_wdata = 8'h00;
    for (int i = 0; i < 256; i++) begin
      v = (i < 4) ? 8'(8'h10 + i) : 8'(i ^ 8'hC3);
      model_mem[i] = v;
      dut.mem[i]   = v;
    end

    // Reset state and idle bus, before and after a clock edge in reset.
    #2;
    check_all_zero("reset0");
    #6;
    check_all_zero("reset1");

    // Release at 10 ns: running at the next edge, then one fetch per 2 cycles.
    #2 RST = 1'b1;
    @(posedge CLK); #1;
    check8("run_is_running", {7'b0, is_running}, 8'h01);
    check8("run_pc0", pc, 8'h00);
    check8("run_ir0", ir, 8'h00);
    for (int k = 1; k <= 4; k++) begin
      repeat (2) @(posedge CLK);
      #1;
      check8("step_pc", pc, 8'(k));
      check8("step_ir", ir, 8'(8'h0F + k));
    end

    // Run past the wrap of pc.
    repeat (520) @(posedge CLK);
    #1;
    check8("wrap_seen", {7'b0, wrap_seen}, 8'h01);

    // Back-to-back host writes then read; pc frozen, 2-cycle cadence.
    host_xfer(1'b0, 8'hFF, 8'hAA, 8'h00, 1'b1, cyc);
    p_frz = pc;
    host_xfer(1'b0, 8'hFE, 8'hAB, 8'h00, 1'b1, cyc);
    check8("b2b_cycles_w2", 8'(cyc), 8'd2);
    check8("frozen_pc_w2", pc, p_frz);
    host_xfer(1'b0, 8'hFD, 8'hAC, 8'h00, 1'b1, cyc);
    check8("b2b_cycles_w3", 8'(cyc), 8'd2);
    check8("frozen_pc_w3", pc, p_frz);
    host_xfer(1'b1, 8'hFF, 8'h00, 8'hAA, 1'b0, cyc);
    check8("b2b_cycles_rd", 8'(cyc), 8'd2);
    check8("frozen_pc_rd", pc, p_frz);
    check8("host_rdata_ff", host_if.host_rdata, 8'hAA);
    check8("done_count", 8'(n_done), 8'd4);
    @(posedge CLK); #1;
    check8("done_single_cycle", {7'b0, host_if.host_done}, 8'h00);

    // Host read while the machine runs.
    repeat (5) @(posedge CLK);
    #1;
    host_xfer(1'b1, 8'h01, 8'h00, 8'h11, 1'b0, cyc);
    repeat (12) @(posedge CLK);
    #1;

    // Reset during the DATA cycle of a host write to 8'h80.
    p0 = pc;
    moved = 1'b0;
    for (int c = 0; c < 6 && !moved; c++) begin
      @(posedge CLK); #1;
      if (pc != p0) moved = 1'b1;
    end
    check8("pc_moved_before_abort", {7'b0, moved}, 8'h01);
    host_if.host_rd    = 1'b0;
    host_if.host_addr  = 8'h80;
    host_if.host_wdata = 8'h55;
    host_if.host_valid = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    host_if.host_valid = 1'b0;
    #1;
    check_all_zero("abort");
    @(posedge CLK); #1;
    check8("abort_bus_idle", uni_bus, 8'h00);
    @(negedge CLK);
    RST = 1'b1;
    repeat (6) @(posedge CLK);
    #1;
    host_xfer(1'b1, 8'h80, 8'h00, 8'h43, 1'b0, cyc);
    host_xfer(1'b1, 8'hFE, 8'h00, 8'hAB, 1'b0, cyc);
    repeat (20) @(posedge CLK);
    #1;

    check8("queue_empty", 8'(host_q.size()), 8'd0);
    check8("fetch_count_ok", {7'b0, (n_fetch >= 260)}, 8'h01);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
